// File: rtl/pkt_checker_pkg.sv
// ---------------------------------------------------------------------------
// pkt_checker_pkg
//   Shared types and constants for the packet stream checker:
//   checker FSM state encoding, LFSR feedback mask, default seed and the
//   single-step LFSR function used by lfsr32.
// ---------------------------------------------------------------------------
package pkt_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  // x^32 + x^22 + x^2 + x + 1, Galois form, right shift
  localparam logic [31:0] LFSR_MASK    = 32'h80200003;
  localparam logic [31:0] DEFAULT_SEED = 32'hBAADF00D;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : '0);
  endfunction

endpackage

// File: rtl/pkt_stream_checker_lfsr32.sv
// ---------------------------------------------------------------------------
// lfsr32
//   32-bit Galois LFSR (right shift, mask LFSR_MASK). Load has priority over
//   step. RESET_STATE is the value taken on asynchronous reset; keep it
//   nonzero or the register locks up.
// Ports
//   clk_rtl  in   clock
//   rst_n    in   asynchronous active-low reset
//   i_load   in   load i_seed into the state
//   i_seed   in   32-bit reload value
//   i_step   in   advance one LFSR step
//   o_state  out  current 32-bit state
// ---------------------------------------------------------------------------
import pkt_checker_pkg::*;

module lfsr32 #(
  parameter logic [31:0] RESET_STATE = DEFAULT_SEED
) (
  input  logic        clk_rtl,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_seed,
  input  logic        i_step,
  output logic [31:0] o_state
);

  logic [31:0] r_state;

  always_ff @(posedge clk_rtl or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RESET_STATE;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_step) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/pkt_stream_checker.sv
// ---------------------------------------------------------------------------
// pkt_stream_checker
//   Receive-side stream checker. Regenerates the sender's LFSR sequence and
//   compares every accepted beat, keeping receive/fail counts, index of the
//   first failure and the accept-window length in cycles.
//
// Optional feature: define CHECKER_BACKPRESSURE_EN to gate i_ready_out with a
//   second free-running LFSR (seed ~SEED) that models a stalling consumer;
//   ready is high in RUN when bp_lfsr[3:0] >= BP_THRESH.
//
// Ports
//   clk_rtl           in   clock
//   rst_n             in   asynchronous active-low reset
//   i_start           in   arm / re-arm pulse (ignored while running)
//   i_data_in         in   received beat
//   i_valid_in        in   beat valid
//   i_ready_out       out  registered ready, independent of i_valid_in
//   o_mismatch        out  pulse: previously accepted beat mismatched
//   o_num_rx          out  beats accepted since arm
//   o_num_fail        out  mismatching beats since arm
//   o_first_fail_idx  out  index of first mismatch, all-ones if none
//   o_cycles          out  cycles from first to last accept, inclusive
//   o_done            out  N_EXPECTED beats received
//   o_pass            out  done with no failures
// ---------------------------------------------------------------------------
import pkt_checker_pkg::*;

module pkt_stream_checker #(
  parameter int unsigned WIDTH_DATA = 16,
  parameter int unsigned N_EXPECTED = 1000,
  parameter logic [31:0] SEED       = DEFAULT_SEED,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned BP_THRESH  = 4
) (
  input  logic                  clk_rtl,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [WIDTH_DATA-1:0] i_data_in,
  input  logic                  i_valid_in,
  output logic                  i_ready_out,
  output logic                  o_mismatch,
  output logic [CNT_WIDTH-1:0]  o_num_rx,
  output logic [CNT_WIDTH-1:0]  o_num_fail,
  output logic [CNT_WIDTH-1:0]  o_first_fail_idx,
  output logic [CNT_WIDTH-1:0]  o_cycles,
  output logic                  o_done,
  output logic                  o_pass
);

  localparam logic [CNT_WIDTH-1:0] C_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] C_LAST = CNT_WIDTH'(N_EXPECTED - 1);

  chk_state_t           r_state;
  chk_state_t           w_state_nxt;
  logic                 w_ready_nxt;
  logic                 r_ready;
  logic                 r_mismatch;
  logic [CNT_WIDTH-1:0] r_num_rx;
  logic [CNT_WIDTH-1:0] r_num_fail;
  logic [CNT_WIDTH-1:0] r_first_fail;
  logic [CNT_WIDTH-1:0] r_cycles;

  logic                 w_arm;
  logic                 w_acc;
  logic                 w_last;
  logic                 w_miss;
  logic [31:0]          w_exp_state;
  logic                 w_unused;

  assign w_acc  = i_valid_in && r_ready;
  // i_start only arms from IDLE/DONE; in RUN it is ignored
  assign w_arm  = i_start && (r_state != RUN);
  assign w_last = w_acc && (r_num_rx == C_LAST);
  assign w_miss = w_acc && (i_data_in != w_exp_state[WIDTH_DATA-1:0]);

  lfsr32 #(
    .RESET_STATE(SEED)
  ) u_exp_lfsr (
    .clk_rtl (clk_rtl),
    .rst_n   (rst_n),
    .i_load  (w_arm),
    .i_seed  (SEED),
    .i_step  (w_acc),
    .o_state (w_exp_state)
  );

`ifdef CHECKER_BACKPRESSURE_EN
  localparam logic [3:0] C_BP_THRESH = 4'(BP_THRESH);

  logic [31:0] w_bp_state;

  lfsr32 #(
    .RESET_STATE(~SEED)
  ) u_bp_lfsr (
    .clk_rtl (clk_rtl),
    .rst_n   (rst_n),
    .i_load  (w_arm),
    .i_seed  (~SEED),
    .i_step  (r_state == RUN),
    .o_state (w_bp_state)
  );

  assign w_unused = ^{w_exp_state, w_bp_state};
`else
  assign w_unused = ^{w_exp_state, 4'(BP_THRESH)};
`endif

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_rtl or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = 1'b0;
    unique case (r_state)
      IDLE, DONE: if (i_start) w_state_nxt = RUN;
      RUN:        if (w_last)  w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
    // Ready is a function of the next state so it drops in the same update
    // that takes the final beat, and rises the cycle after arming.
`ifdef CHECKER_BACKPRESSURE_EN
    w_ready_nxt = (w_state_nxt == RUN) && (w_bp_state[3:0] >= C_BP_THRESH);
`else
    w_ready_nxt = (w_state_nxt == RUN);
`endif
  end

  // ---------------------------------------------------------------------
  // Comparator and statistics
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_rtl or negedge rst_n) begin
    if (!rst_n) begin
      r_ready      <= 1'b0;
      r_mismatch   <= 1'b0;
      r_num_rx     <= '0;
      r_num_fail   <= '0;
      r_first_fail <= '1;
      r_cycles     <= '0;
    end else begin
      r_ready    <= w_ready_nxt;
      r_mismatch <= w_miss;
      if (w_arm) begin
        r_num_rx     <= '0;
        r_num_fail   <= '0;
        r_first_fail <= '1;
        r_cycles     <= '0;
      end else if (r_state == RUN) begin
        if (w_acc && (r_num_rx != '1)) begin
          r_num_rx <= r_num_rx + C_ONE;
        end
        if (w_miss) begin
          if (r_num_fail != '1) begin
            r_num_fail <= r_num_fail + C_ONE;
          end
          if (r_first_fail == '1) begin
            r_first_fail <= r_num_rx;
          end
        end
        // Zero means "no beat accepted yet"; the first accept loads 1 and
        // every later RUN cycle counts, saturating at all-ones.
        if (r_cycles == '0) begin
          if (w_acc) begin
            r_cycles <= C_ONE;
          end
        end else if (r_cycles != '1) begin
          r_cycles <= r_cycles + C_ONE;
        end
      end
    end
  end

  assign i_ready_out      = r_ready;
  assign o_mismatch       = r_mismatch;
  assign o_num_rx         = r_num_rx;
  assign o_num_fail       = r_num_fail;
  assign o_first_fail_idx = r_first_fail;
  assign o_cycles         = r_cycles;
  assign o_done           = (r_state == DONE);
  assign o_pass           = (r_state == DONE) && (r_num_fail == '0);

endmodule
